// File: rtl/stopwatch_pkg.sv
// Shared definitions for the minutes:seconds BCD stopwatch: state encoding,
// per-digit limits and the default one-second prescaler length.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sw_state_t;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 5;

    localparam int DEFAULT_TICK_CYCLES = 100_000_000;

    // Packs the four digits into the display word, most significant first.
    function automatic logic [15:0] pack_bcd(
        input logic [3:0] min_tens,
        input logic [3:0] min_ones,
        input logic [3:0] sec_tens,
        input logic [3:0] sec_ones
    );
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// One BCD digit that counts 0..MAX; carry is combinational so a chain of
// these advances every affected digit on the same edge.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = SEC_ONES_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    localparam logic [3:0] MAX_DIGIT = 4'(MAX);

    assign carry = inc && (digit == MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch producing a packed BCD display word from a one-second tick.
// Define STOPWATCH_LAP_HOLD_EN to enable the lap (display hold) feature.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] number,
    output logic        running,
    output logic        wrap,
    output logic        lap_active
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    sw_state_t     state;
    sw_state_t     state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          tick;

    logic [3:0]    sec_ones;
    logic [3:0]    sec_tens;
    logic [3:0]    min_ones;
    logic [3:0]    min_tens;
    logic          carry_sec_ones;
    logic          carry_sec_tens;
    logic          carry_min_ones;
    logic          carry_min_tens;
    logic [15:0]   live_count;

    // A start_stop landing on the tick cycle pauses instead of counting, and
    // the prescaler parks at its last value so resume ticks immediately.
    always_comb begin
        state_next = state;
        presc_next = presc;
        tick       = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            presc_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    presc_next = '0;
                    if (start_stop) begin
                        state_next = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (start_stop) begin
                        state_next = ST_PAUSED;
                    end
                    if (presc == PRESC_LAST) begin
                        if (!start_stop) begin
                            tick       = 1'b1;
                            presc_next = '0;
                        end
                    end else begin
                        presc_next = presc + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (start_stop) begin
                        state_next = ST_RUNNING;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    presc_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            presc   <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            running <= (state_next == ST_RUNNING);
            wrap    <= carry_min_tens;
        end
    end

    bcd_mod_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .inc   (tick),
        .clr   (clear),
        .digit (sec_ones),
        .carry (carry_sec_ones)
    );

    bcd_mod_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_sec_ones),
        .clr   (clear),
        .digit (sec_tens),
        .carry (carry_sec_tens)
    );

    bcd_mod_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_sec_tens),
        .clr   (clear),
        .digit (min_ones),
        .carry (carry_min_ones)
    );

    bcd_mod_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_min_ones),
        .clr   (clear),
        .digit (min_tens),
        .carry (carry_min_tens)
    );

    assign live_count = pack_bcd(min_tens, min_ones, sec_tens, sec_ones);

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        hold_q;
    logic [15:0] hold_value;

    // The snapshot is the value on display in the lap cycle, even if a tick
    // advances the live count on that same edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hold_q     <= 1'b0;
            hold_value <= 16'h0000;
        end else if (lap && (state != ST_IDLE)) begin
            hold_q <= !hold_q;
            if (!hold_q) begin
                hold_value <= live_count;
            end
        end
    end

    assign number     = hold_q ? hold_value : live_count;
    assign lap_active = hold_q;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign number     = live_count;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter with TICK_CYCLES=4; honours
// STOPWATCH_LAP_HOLD_EN so it can be built with or without the lap feature.
module tb_stopwatch_bcd_counter;

    localparam int TICK = 4;
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] number;
    logic        running;
    logic        wrap;
    logic        lap_active;

    int n_compared = 0;
    int n_mismatched = 0;

    stopwatch_bcd_counter #(.TICK_CYCLES(TICK)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .number     (number),
        .running    (running),
        .wrap       (wrap),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    // Model: elapsed whole seconds as an integer plus the fraction of the
    // current second, rebuilt into BCD only when compared.
    int m_state = 0;
    int m_secs = 0;
    int m_phase = 0;
    int m_held = 0;
    bit m_hold = 1'b0;
    bit m_wrap = 1'b0;
    bit m_valid = 1'b0;

    function automatic logic [31:0] to_bcd(input int s);
        int m;
        int sec;
        m = s / 60;
        sec = s % 60;
        return {16'h0000, 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic cl, input logic lp, input logic rs);
        @(negedge clk);
        start_stop = ss;
        clear = cl;
        lap = lp;
        reset = rs;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        int st;
        int secs;
        int ph;
        int held;
        bit hd;
        bit wr;
        st = m_state;
        secs = m_secs;
        ph = m_phase;
        held = m_held;
        hd = m_hold;
        wr = 1'b0;
        if (reset || clear) begin
            st = 0;
            secs = 0;
            ph = 0;
            held = 0;
            hd = 1'b0;
        end else begin
            if (LAP_EN && lap && m_state != 0) begin
                if (!m_hold) held = m_secs;
                hd = !m_hold;
            end
            if (m_state == 0) begin
                if (start_stop) st = 1;
            end else if (m_state == 1) begin
                if (start_stop) begin
                    st = 2;
                    if (m_phase < TICK - 1) ph = m_phase + 1;
                end else if (m_phase == TICK - 1) begin
                    ph = 0;
                    secs = (m_secs + 1) % 3600;
                    wr = (secs == 0);
                end else begin
                    ph = m_phase + 1;
                end
            end else begin
                if (start_stop) st = 1;
            end
        end
        m_state <= st;
        m_secs <= secs;
        m_phase <= ph;
        m_held <= held;
        m_hold <= hd;
        m_wrap <= wr;
        m_valid <= m_valid | reset;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cyc_number", 32'(number), to_bcd(m_hold ? m_held : m_secs));
            checkOutput("cyc_running", 32'(running), (m_state == 1) ? 32'd1 : 32'd0);
            checkOutput("cyc_wrap", 32'(wrap), 32'(m_wrap));
            checkOutput("cyc_lap_active", 32'(lap_active), 32'(m_hold));
        end
    end

    initial begin
        int budget;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        checkOutput("reset_number", 32'(number), 32'h0000);
        checkOutput("reset_running", 32'(running), 32'd0);

        $display("[TB] start and count through 0009 -> 0010");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        checkOutput("first_tick_pending", 32'(number), 32'h0000);
        checkOutput("running_after_start", 32'(running), 32'd1);
        idle(1);
        checkOutput("first_tick", 32'(number), 32'h0001);
        idle(35);
        checkOutput("count_0009", 32'(number), 32'h0009);
        idle(1);
        checkOutput("carry_0010", 32'(number), 32'h0010);
        idle(8);
        checkOutput("count_0012", 32'(number), 32'h0012);

        $display("[TB] clear together with start_stop");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("clear_number", 32'(number), 32'h0000);
        checkOutput("clear_running", 32'(running), 32'd0);

        $display("[TB] pause mid-second and resume");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        checkOutput("pre_pause", 32'(number), 32'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(50);
        checkOutput("paused_number", 32'(number), 32'h0001);
        checkOutput("paused_running", 32'(running), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        checkOutput("resume_hold", 32'(number), 32'h0001);
        idle(1);
        checkOutput("resume_tick", 32'(number), 32'h0002);

        $display("[TB] lap hold");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checkOutput("lap_in_idle", 32'(lap_active), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(13);
        checkOutput("lap_start_value", 32'(number), 32'h0003);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        if (LAP_EN) begin
            checkOutput("lap_held_number", 32'(number), 32'h0003);
            checkOutput("lap_held_flag", 32'(lap_active), 32'd1);
        end else begin
            checkOutput("lap_ignored_number", 32'(number), 32'h0005);
            checkOutput("lap_ignored_flag", 32'(lap_active), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checkOutput("lap_release_number", 32'(number), 32'h0005);
        checkOutput("lap_release_flag", 32'(lap_active), 32'd0);

        $display("[TB] run to 59:59 and wrap");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        budget = 0;
        while (number !== 16'h5959 && budget < 20000) begin
            idle(1);
            budget++;
        end
        checkOutput("cycles_to_5959", 32'(budget), 32'd14397);
        budget = 0;
        while (number === 16'h5959 && budget < 8) begin
            idle(1);
            budget++;
        end
        checkOutput("cycles_5959_shown", 32'(budget), 32'd4);
        checkOutput("wrap_number", 32'(number), 32'h0000);
        checkOutput("wrap_pulse", 32'(wrap), 32'd1);
        idle(1);
        checkOutput("wrap_one_cycle", 32'(wrap), 32'd0);

        $display("[TB] reset mid-count");
        idle(9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        checkOutput("reset_mid_number", 32'(number), 32'h0000);
        checkOutput("reset_mid_running", 32'(running), 32'd0);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Minutes:seconds stopwatch that produces the packed 16-bit BCD `number` word consumed by the seven-segment display driver. It divides the system clock down to a one-second tick, runs a four-digit BCD count from 00:00 to 59:59 with wrap-around, and is controlled by single-cycle start/stop and clear pulses from the debounced button logic.

## Interface
- `TICK_CYCLES`, default 100_000_000: clock cycles per one-second tick; must be ≥ 2.
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start_stop`  in  1: single-cycle pulse that toggles run/pause.
- `clear`  in  1: single-cycle pulse that zeros the count and returns to IDLE.
- `lap`  in  1: single-cycle pulse that toggles display hold; used only with `LAP_HOLD_EN`.
- `number`  out  16: packed BCD value, registered.
  - [15:12] tens of minutes, 0–5.
  - [11:8] ones of minutes, 0–9.
  - [7:4] tens of seconds, 0–5.
  - [3:0] ones of seconds, 0–9.
- `running`  out  1: high while in RUNNING.
- `wrap`  out  1: one-cycle pulse when the count wraps 59:59 → 00:00.
- `lap_active`  out  1: high while the display is held.

## Operation
- States and transitions:
  - IDLE: count is 00:00, stopped.
  - IDLE → RUNNING on `start_stop`.
  - RUNNING → PAUSED on `start_stop`.
  - PAUSED → RUNNING on `start_stop`.
  - Any state → IDLE on `clear` or `reset`.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 only in RUNNING.
  - The tick fires when the prescaler equals TICK_CYCLES-1 in RUNNING; the prescaler then returns to 0.
  - Holds its value in PAUSED, so the partial second is preserved.
  - Forced to 0 in IDLE.
- Count increment on each tick:
  - ones-seconds +1; at 9 it wraps to 0 and carries.
  - tens-seconds wraps at 5; ones-minutes wraps at 9; tens-minutes wraps at 5.
  - A full carry out of tens-minutes yields 00:00 and asserts `wrap`.
- Digits are never out of range; no binary-to-BCD conversion is performed.
- Priority, highest first: `reset` > `clear` > `start_stop` > tick.
  - `clear` with `start_stop` in the same cycle gives IDLE.
  - `start_stop` in RUNNING on a tick cycle goes to PAUSED, and that tick is suppressed (no increment; prescaler holds at TICK_CYCLES-1).
  - On resume, the first increment occurs one cycle after entering RUNNING.
- IDLE holds `number` = 0 regardless of inputs other than `start_stop`.

## Timing
- Reset values:
  - `number` = 16'h0000
  - `running` = 0
  - `wrap` = 0
  - `lap_active` = 0
  - state = IDLE
  - prescaler = 0
- Latency:
  - `number` changes on the clock edge ending the tick cycle, visible the following cycle.
  - `wrap` asserts in the same cycle that `number` first shows 00:00 after 59:59, for exactly one cycle.
  - `running` is registered and updates on the edge that samples `start_stop`/`clear`.
- First tick after start from IDLE: `number` = 00:01 is visible TICK_CYCLES cycles after the `start_stop` cycle.
- Reset or `clear` mid-count: on the next cycle all outputs show reset values, and prescaler progress is discarded.

## Configuration
- `STOPWATCH_LAP_HOLD_EN` defined:
  - A `lap` pulse in RUNNING or PAUSED toggles hold.
  - While held, `number` stays frozen at the value it had when hold began, while the internal count keeps advancing; `lap_active` = 1.
  - Releasing hold makes `number` show the live count on the next cycle.
  - `clear`/`reset` release the hold.
  - `lap` is ignored in IDLE.
  - `wrap` still reflects the internal count.
- Not defined:
  - The `lap` port exists but is ignored.
  - `lap_active` is tied to 0.
  - `number` always shows the live count.

## Structure
- Shared package `stopwatch_pkg`:
  - state encoding (IDLE, RUNNING, PAUSED)
  - digit limit constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5)
  - default TICK_CYCLES
- Sub-module `bcd_mod_counter`:
  - one BCD digit with parameter MAX, inputs `inc`/`clr`, outputs `digit[3:0]` and `carry` (carry = inc && digit==MAX).
  - Instantiated four times in a carry chain.

## Test plan
- Use TICK_CYCLES=4 throughout.
- Reset, then hold inputs idle 20 cycles → `number`=0000, `running`=0, `wrap`=0 throughout.
- Start pulse, run 40 cycles → `number` steps 0001…0010 each 4 cycles; 0009→0010 carry is correct.
- Preload via run to 5959, then one more tick → `number`=0000 and `wrap` high for exactly 1 cycle.
- Start, pause after 6 cycles (prescaler mid-count), wait 50 cycles, resume → `number` frozen at 0001 during pause; next increment 2 cycles after resume.
- `clear` and `start_stop` in the same cycle while RUNNING at 0012 → next cycle `number`=0000, `running`=0, state IDLE.
- With `STOPWATCH_LAP_HOLD_EN`: lap at 0003, run 8 cycles, lap again → `number` holds 0003 with `lap_active`=1, then shows 0005 the cycle after release.
